// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared types and helpers for the memory-stage sequencer:
//   access size encoding, data bus request/response records, sequencer
//   state enum, store strobe/size helpers and load lane extraction.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } mac_state_t;

  function automatic logic [3:0] msize_to_bytes(input msize_t s);
    case (s)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  // Strobe is placed on the naturally aligned lane containing lo.
  function automatic logic [7:0] msize_to_strobe(input msize_t s, input logic [2:0] lo);
    case (s)
      MSIZE1:  return 8'b0000_0001 << lo;
      MSIZE2:  return 8'b0000_0011 << {lo[2:1], 1'b0};
      MSIZE4:  return 8'b0000_1111 << {lo[2], 2'b00};
      default: return 8'hFF;
    endcase
  endfunction

  // Pipeline load-alignment: pick the lane selected by lo, then extend.
  function automatic logic [63:0] load_align(input logic [63:0] d, input logic [2:0] lo,
                                             input msize_t s, input logic uns);
    logic [5:0]  sh;
    logic [63:0] v;
    case (s)
      MSIZE1:  sh = {lo, 3'b000};
      MSIZE2:  sh = {lo[2:1], 4'b0000};
      MSIZE4:  sh = {lo[2], 5'b00000};
      default: sh = '0;
    endcase
    v = d >> sh;
    case (s)
      MSIZE1:  v = uns ? {56'd0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
      MSIZE2:  v = uns ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
      MSIZE4:  v = uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
      default: v = d;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// mem_store_align
//   Combinational store lane placement.
//   addr_lo_i : byte address bits [2:0]
//   msize_i   : access size
//   wdata_i   : LSB-aligned store data
//   strobe_o  : byte enables for the 64-bit bus word
//   data_o    : store data shifted onto its byte lane (zero fill)
module mem_store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  addr_lo_i,
  input  msize_t      msize_i,
  input  logic [63:0] wdata_i,
  output logic [7:0]  strobe_o,
  output logic [63:0] data_o
);

  always_comb begin
    strobe_o = msize_to_strobe(msize_i, addr_lo_i);
    data_o   = wdata_i << {addr_lo_i, 3'b000};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage sequencer: accepts one load/store/pass-through op per
//   handshake, runs the dbus transaction to completion, aligns/extends
//   load data and presents a result to the writeback register.
//   Optional macro MISALIGN_CHECK_EN: misaligned accesses skip the bus and
//   complete with out_misalign=1; otherwise out_misalign is tied 0.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       upstream handshake
//   in_is_load/in_is_store  op kind (neither = pass-through)
//   in_addr/in_wdata        byte address, LSB-aligned store data
//   in_msize/in_unsigned    access size, zero-extend loads
//   flush                   kill current and incoming op
//   dreq/dresp              data bus request/response
//   out_valid/out_ready     downstream handshake
//   out_rdata               aligned load data (0 for store/pass-through)
//   out_misalign            misaligned access flag
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  msize_t            in_msize,
  input  logic              in_unsigned,
  input  logic              flush,
  output dbus_req_t         dreq,
  input  dbus_resp_t        dresp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata,
  output logic              out_misalign
);

  if (DATA_W != 64) begin : g_bad_data_w
    $error("mem_access_ctrl: DATA_W must be 64");
  end
  if (ADDR_W < 4 || ADDR_W > 64) begin : g_bad_addr_w
    $error("mem_access_ctrl: ADDR_W must be within 4..64");
  end

  mac_state_t        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              kill_q, kill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  msize_t            size_q, size_d;
  logic              uns_q, uns_d;
  logic              is_load_q, is_load_d;

  logic              accept;
  logic              pop;
  logic              complete;
  logic [63:0]       addr_ext;
  logic [7:0]        st_strobe;
  logic [63:0]       st_data;

`ifdef MISALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
  logic [3:0]        nbytes;
  logic              misaligned;

  always_comb begin
    nbytes     = msize_to_bytes(in_msize);
    misaligned = |(in_addr[2:0] & 3'(nbytes - 4'd1));
  end

  assign out_misalign = misalign_q;
`else
  assign out_misalign = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE) && !(out_valid_q && !out_ready);
  assign out_valid = out_valid_q;
  assign out_rdata = rdata_q;

  mem_store_align u_store_align (
    .addr_lo_i (addr_q[2:0]),
    .msize_i   (size_q),
    .wdata_i   (wdata_q),
    .strobe_o  (st_strobe),
    .data_o    (st_data)
  );

  // Request fields come only from latched state so they stay stable
  // for the whole transaction regardless of upstream activity.
  always_comb begin
    addr_ext              = '0;
    addr_ext[ADDR_W-1:0]  = addr_q;
    dreq.valid            = (state_q == REQ) || (state_q == DATA);
    dreq.addr             = addr_ext & ~64'h7;
    dreq.size             = size_q;
    dreq.strobe           = is_load_q ? '0 : st_strobe;
    dreq.data             = is_load_q ? '0 : st_data;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    rdata_d     = rdata_q;
    kill_d      = kill_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    is_load_d   = is_load_q;
`ifdef MISALIGN_CHECK_EN
    misalign_d  = misalign_q;
`endif
    complete    = 1'b0;
    accept      = in_valid && in_ready && !flush;
    pop         = out_valid_q && out_ready;

    case (state_q)
      IDLE: begin
        // Pass-through results live in IDLE so a new op can follow each cycle.
        if (pop || flush) out_valid_d = 1'b0;
        if (accept) begin
          if (in_is_load || in_is_store) begin
            addr_d    = in_addr;
            wdata_d   = in_wdata;
            size_d    = in_msize;
            uns_d     = in_unsigned;
            is_load_d = in_is_load;
            state_d   = REQ;
`ifdef MISALIGN_CHECK_EN
            if (misaligned) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              rdata_d     = '0;
              misalign_d  = 1'b1;
            end
`endif
          end else begin
            out_valid_d = 1'b1;
            rdata_d     = '0;
`ifdef MISALIGN_CHECK_EN
            misalign_d  = 1'b0;
`endif
          end
        end
      end
      REQ: begin
        if (flush) kill_d = 1'b1;
        if (dresp.addr_ok) begin
          if (dresp.data_ok) complete = 1'b1;
          else               state_d  = DATA;
        end
      end
      DATA: begin
        if (flush) kill_d = 1'b1;
        if (dresp.data_ok) complete = 1'b1;
      end
      DONE: begin
        if (pop || flush) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush seen during the transaction (including the completing cycle)
    // lets the bus finish but discards the result.
    if (complete) begin
      kill_d = 1'b0;
      if (kill_q || flush) begin
        state_d = IDLE;
      end else begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        rdata_d     = is_load_q ? load_align(dresp.data, addr_q[2:0], size_q, uns_q) : '0;
`ifdef MISALIGN_CHECK_EN
        misalign_d  = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      rdata_q     <= '0;
      kill_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= MSIZE1;
      uns_q       <= 1'b0;
      is_load_q   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rdata_q     <= rdata_d;
      kill_q      <= kill_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      is_load_q   <= is_load_d;
`ifdef MISALIGN_CHECK_EN
      misalign_q  <= misalign_d;
`endif
    end
  end

endmodule
